// File: rtl/p4_router_egress_demux.sv
`default_nettype none
// =============================================================================
// Module   : p4_router_egress_demux
// Brief    : Steers whole packets from the VNP4 wrapper to one of NUM_EGR_PORTS
//            AXIS egress streams; drops out-of-range packets and counts both.
// Revision : 1.0 - initial release
// =============================================================================
module p4_router_egress_demux #(
  parameter int DATA_BYTES     = 64,
  parameter int NUM_EGR_PORTS  = 4,
  parameter int EGR_PORT_WIDTH = 4,
  parameter int ING_PORT_WIDTH = 4,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                                     clk,
  input  logic                                     sreset,
  input  logic [8*DATA_BYTES-1:0]                  s_axis_tdata,
  input  logic [DATA_BYTES-1:0]                    s_axis_tkeep,
  input  logic                                     s_axis_tlast,
  input  logic [ING_PORT_WIDTH+EGR_PORT_WIDTH-1:0] s_axis_tuser,
  input  logic                                     s_axis_tvalid,
  output logic                                     s_axis_tready,
  output logic [8*DATA_BYTES-1:0]                  m_axis_tdata,
  output logic [DATA_BYTES-1:0]                    m_axis_tkeep,
  output logic                                     m_axis_tlast,
  output logic [ING_PORT_WIDTH-1:0]                m_axis_tuser,
  output logic [NUM_EGR_PORTS-1:0]                 m_axis_tvalid,
  input  logic [NUM_EGR_PORTS-1:0]                 m_axis_tready,
  output logic [CNT_WIDTH-1:0]                     fwd_pkt_count,
  output logic [CNT_WIDTH-1:0]                     drop_pkt_count,
  output logic                                     drop_pulse
);

  localparam int c_sel_width = (NUM_EGR_PORTS > 1) ? $clog2(NUM_EGR_PORTS) : 1;

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_fwd  = 2'd1;
  localparam logic [1:0] c_drop = 2'd2;

  localparam logic [CNT_WIDTH-1:0] c_cnt_max = {CNT_WIDTH{1'b1}};

  logic [1:0]                r_state;
  logic [1:0]                w_state_next;
  logic [EGR_PORT_WIDTH-1:0] w_in_egr;
  logic [ING_PORT_WIDTH-1:0] w_in_ing;
  logic                      w_port_ok;
  logic                      w_accept;
  logic                      w_sof;
  logic                      w_dropping;
  logic                      w_load;
  logic                      w_drop_sof;
  logic                      w_out_ready;
  logic                      w_fwd_done;
  logic [c_sel_width-1:0]    w_beat_sel;
  logic [ING_PORT_WIDTH-1:0] w_beat_ing;

  logic [c_sel_width-1:0]    r_sel;
  logic [ING_PORT_WIDTH-1:0] r_ing;
  logic                      r_out_valid;
  logic [c_sel_width-1:0]    r_out_sel;
  logic [8*DATA_BYTES-1:0]   r_out_data;
  logic [DATA_BYTES-1:0]     r_out_keep;
  logic                      r_out_last;
  logic [ING_PORT_WIDTH-1:0] r_out_user;
  logic [CNT_WIDTH-1:0]      r_fwd_cnt;
  logic [CNT_WIDTH-1:0]      r_drop_cnt;
  logic                      r_drop_pulse;

  assign w_in_egr  = s_axis_tuser[EGR_PORT_WIDTH-1:0];
  assign w_in_ing  = s_axis_tuser[ING_PORT_WIDTH+EGR_PORT_WIDTH-1:EGR_PORT_WIDTH];
  assign w_port_ok = (32'(w_in_egr) < NUM_EGR_PORTS);

  // ---------------------------------------------------------------------------
  // Packet framing FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (sreset) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_idle: begin
        if (w_accept && !s_axis_tlast) begin
          w_state_next = w_port_ok ? c_fwd : c_drop;
        end
      end
      c_fwd, c_drop: begin
        if (w_accept && s_axis_tlast) begin
          w_state_next = c_idle;
        end
      end
      default: w_state_next = c_idle;
    endcase
  end

  // Dropped beats bypass the output register, so they never wait on egress.
  always_comb begin
    w_sof      = 1'b0;
    w_dropping = 1'b0;
    case (r_state)
      c_idle: begin
        w_sof      = 1'b1;
        w_dropping = !w_port_ok;
      end
      c_fwd:   w_dropping = 1'b0;
      c_drop:  w_dropping = 1'b1;
      default: w_dropping = 1'b0;
    endcase
  end

  assign w_out_ready   = m_axis_tready[r_out_sel];
  assign s_axis_tready = w_dropping || !r_out_valid || w_out_ready;
  assign w_accept      = s_axis_tvalid && s_axis_tready;
  assign w_load        = w_accept && !w_dropping;
  assign w_drop_sof    = w_accept && w_sof && !w_port_ok;
  assign w_fwd_done    = r_out_valid && w_out_ready && r_out_last;

  assign w_beat_sel = w_sof ? w_in_egr[c_sel_width-1:0] : r_sel;
  assign w_beat_ing = w_sof ? w_in_ing : r_ing;

  always_ff @(posedge clk) begin
    if (sreset) begin
      r_sel <= '0;
      r_ing <= '0;
    end else if (w_accept && w_sof && w_port_ok) begin
      r_sel <= w_in_egr[c_sel_width-1:0];
      r_ing <= w_in_ing;
    end
  end

  // ---------------------------------------------------------------------------
  // Output register stage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (sreset) begin
      r_out_valid <= 1'b0;
      r_out_sel   <= '0;
      r_out_data  <= '0;
      r_out_keep  <= '0;
      r_out_last  <= 1'b0;
      r_out_user  <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_sel   <= w_beat_sel;
      r_out_data  <= s_axis_tdata;
      r_out_keep  <= s_axis_tkeep;
      r_out_last  <= s_axis_tlast;
      r_out_user  <= w_beat_ing;
    end else if (w_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  for (genvar i = 0; i < NUM_EGR_PORTS; i++) begin : g_tvalid
    assign m_axis_tvalid[i] = r_out_valid && (r_out_sel == c_sel_width'(i));
  end

  assign m_axis_tdata = r_out_data;
  assign m_axis_tkeep = r_out_keep;
  assign m_axis_tlast = r_out_last;
  assign m_axis_tuser = r_out_user;

  // ---------------------------------------------------------------------------
  // Statistics (saturating)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (sreset) begin
      r_fwd_cnt    <= '0;
      r_drop_cnt   <= '0;
      r_drop_pulse <= 1'b0;
    end else begin
      r_drop_pulse <= w_drop_sof;
      if (w_fwd_done && (r_fwd_cnt != c_cnt_max)) begin
        r_fwd_cnt <= r_fwd_cnt + 1'b1;
      end
      if (w_drop_sof && (r_drop_cnt != c_cnt_max)) begin
        r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end
  end

  assign fwd_pkt_count  = r_fwd_cnt;
  assign drop_pkt_count = r_drop_cnt;
  assign drop_pulse     = r_drop_pulse;

endmodule
`default_nettype wire

// File: tb/tb_p4_router_egress_demux.sv
`default_nettype none
// =============================================================================
// Module   : tb_p4_router_egress_demux
// Brief    : Self-checking bench with a packet-level reference model.
// Revision : 1.1 - checking task
// =============================================================================
module tb_p4_router_egress_demux;

    logic         clk = 1'b0;
    logic         sreset;
    logic [511:0] s_axis_tdata;
    logic [63:0]  s_axis_tkeep;
    logic         s_axis_tlast;
    logic [7:0]   s_axis_tuser;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic [511:0] m_axis_tdata;
    logic [63:0]  m_axis_tkeep;
    logic         m_axis_tlast;
    logic [3:0]   m_axis_tuser;
    logic [3:0]   m_axis_tvalid;
    logic [3:0]   m_axis_tready;
    logic [31:0]  fwd_pkt_count;
    logic [31:0]  drop_pkt_count;
    logic         drop_pulse;

    logic         c4_s_tready;
    logic [511:0] c4_m_tdata;
    logic [63:0]  c4_m_tkeep;
    logic         c4_m_tlast;
    logic [3:0]   c4_m_tuser;
    logic [3:0]   c4_m_tvalid;
    logic [3:0]   c4_fwd;
    logic [3:0]   c4_drop;
    logic         c4_drop_pulse;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    p4_router_egress_demux u_dut (
        .clk(clk), .sreset(sreset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .fwd_pkt_count(fwd_pkt_count), .drop_pkt_count(drop_pkt_count),
        .drop_pulse(drop_pulse)
    );

    // Narrow-counter build fed the same stream, used for saturation.
    p4_router_egress_demux #(.CNT_WIDTH(4)) u_dut_c4 (
        .clk(clk), .sreset(sreset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(c4_s_tready),
        .m_axis_tdata(c4_m_tdata), .m_axis_tkeep(c4_m_tkeep),
        .m_axis_tlast(c4_m_tlast), .m_axis_tuser(c4_m_tuser),
        .m_axis_tvalid(c4_m_tvalid), .m_axis_tready(m_axis_tready),
        .fwd_pkt_count(c4_fwd), .drop_pkt_count(c4_drop),
        .drop_pulse(c4_drop_pulse)
    );

    // -------------------------------------------------------------------------
    // Reference model: per-port expected beat queues plus packet-level counters
    // -------------------------------------------------------------------------
    typedef struct {
        logic [511:0] data;
        logic [63:0]  keep;
        logic         last;
        logic [3:0]   user;
        int           acc;
    } beat_t;

    beat_t        exp_q [4][$];
    beat_t        it;
    beat_t        hold;
    logic [3:0]   hold_tvalid;
    bit           hold_valid;
    bit           in_pkt;
    bit           cur_drop;
    logic [3:0]   cur_port;
    logic [3:0]   cur_ing;
    logic [31:0]  exp_fwd;
    logic [31:0]  exp_drop;
    logic [3:0]   exp_fwd4;
    logic [3:0]   exp_drop4;
    logic         exp_pulse;
    int           cyc = 0;
    int           last_stall = 0;

    always @(negedge clk) begin
        if (sreset) begin
            for (int p = 0; p < 4; p++) exp_q[p].delete();
            in_pkt = 0; cur_drop = 0; cur_port = '0; cur_ing = '0;
            exp_fwd = '0; exp_drop = '0; exp_fwd4 = '0; exp_drop4 = '0;
            exp_pulse = 1'b0; hold_valid = 0;
        end else begin
            cyc++;
            if (m_axis_tready != 4'hF) last_stall = cyc;
            chk("valid_onehot", ($countones(m_axis_tvalid) <= 1), 1'b1);
            chk("fwd_cnt", fwd_pkt_count, exp_fwd);
            chk("drop_cnt", drop_pkt_count, exp_drop);
            chk("fwd_cnt_w4", c4_fwd, exp_fwd4);
            chk("drop_cnt_w4", c4_drop, exp_drop4);
            chk("drop_pulse", drop_pulse, exp_pulse);
            if (hold_valid) begin
                chk("hold_tvalid", m_axis_tvalid, hold_tvalid);
                chk("hold_tdata", m_axis_tdata, hold.data);
                chk("hold_tkeep", m_axis_tkeep, hold.keep);
                chk("hold_tlast", m_axis_tlast, hold.last);
                chk("hold_tuser", m_axis_tuser, hold.user);
            end
            hold_valid = 0;
            for (int p = 0; p < 4; p++) begin
                if (m_axis_tvalid[p] && !m_axis_tready[p]) begin
                    hold_valid  = 1;
                    hold_tvalid = m_axis_tvalid;
                    hold.data   = m_axis_tdata;
                    hold.keep   = m_axis_tkeep;
                    hold.last   = m_axis_tlast;
                    hold.user   = m_axis_tuser;
                end else if (m_axis_tvalid[p]) begin
                    chk("beat_expected_on_port", (exp_q[p].size() != 0), 1'b1);
                    if (exp_q[p].size() != 0) begin
                        it = exp_q[p].pop_front();
                        chk("egress_tdata", m_axis_tdata, it.data);
                        chk("egress_tkeep", m_axis_tkeep, it.keep);
                        chk("egress_tlast", m_axis_tlast, it.last);
                        chk("egress_tuser", m_axis_tuser, it.user);
                        if (it.acc > last_stall) chk("latency", cyc, it.acc + 1);
                        if (it.last) begin
                            if (exp_fwd != '1) exp_fwd = exp_fwd + 1;
                            if (exp_fwd4 != '1) exp_fwd4 = exp_fwd4 + 1;
                        end
                    end
                end
            end
            exp_pulse = 1'b0;
            if (s_axis_tvalid && s_axis_tready) begin
                if (!in_pkt) begin
                    cur_port = s_axis_tuser[3:0];
                    cur_ing  = s_axis_tuser[7:4];
                    cur_drop = (cur_port >= 4);
                    if (cur_drop) begin
                        exp_pulse = 1'b1;
                        if (exp_drop != '1) exp_drop = exp_drop + 1;
                        if (exp_drop4 != '1) exp_drop4 = exp_drop4 + 1;
                    end
                end
                in_pkt = !s_axis_tlast;
                if (!cur_drop) begin
                    it.data = s_axis_tdata;
                    it.keep = s_axis_tkeep;
                    it.last = s_axis_tlast;
                    it.user = cur_ing;
                    it.acc  = cyc;
                    exp_q[cur_port[1:0]].push_back(it);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers (entered and left at posedge + 1)
    // -------------------------------------------------------------------------
    task automatic send_beat(input logic [7:0] user, input logic last, input bit chk_ready);
        int waited = 0;
        for (int i = 0; i < 16; i++) s_axis_tdata[i*32 +: 32] = $urandom;
        s_axis_tkeep  = {$urandom, $urandom};
        s_axis_tlast  = last;
        s_axis_tuser  = user;
        s_axis_tvalid = 1'b1;
        @(negedge clk);
        if (chk_ready) chk("tready_immediate", s_axis_tready, 1'b1);
        while (!s_axis_tready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!s_axis_tready) begin
            n_checks++;
            n_fail++;
            $error("FAIL accept_timeout: s_axis_tready low for %0d cycles", waited);
        end
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic send_pkt(input logic [3:0] egr, input int nbeats, input bit chk_ready, input int gap_max);
        logic [3:0] ing;
        ing = 4'($urandom);
        for (int b = 0; b < nbeats; b++) begin
            send_beat((b == 0) ? {ing, egr} : 8'($urandom), (b == nbeats - 1), chk_ready);
            repeat ($urandom_range(gap_max, 0)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    bit rnd_done;

    initial begin
        sreset        = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = '0;
        m_axis_tready = 4'hF;
        repeat (3) @(posedge clk);
        #1 sreset = 1'b0;

        @(negedge clk);
        chk("rst_tready", s_axis_tready, 1'b1);
        chk("rst_tvalid", m_axis_tvalid, 4'h0);
        chk("rst_tdata", m_axis_tdata, 512'h0);
        chk("rst_tlast", m_axis_tlast, 1'b0);
        chk("rst_tuser", m_axis_tuser, 4'h0);
        @(posedge clk);
        #1;

        // Three 4-beat packets to ports 0, 1, 3 at full rate
        send_pkt(4'd0, 4, 1, 0);
        send_pkt(4'd1, 4, 1, 0);
        send_pkt(4'd3, 4, 1, 0);
        idle(4);
        chk("fwd_after_three", fwd_pkt_count, 32'd3);

        // Out-of-range port dropped, then a good packet to port 2
        send_pkt(4'd5, 3, 1, 0);
        send_pkt(4'd2, 3, 0, 0);
        idle(4);
        chk("drop_after_one", drop_pkt_count, 32'd1);
        chk("fwd_after_port2", fwd_pkt_count, 32'd4);

        // tuser on later beats points elsewhere; packet must stay on port 0
        send_beat(8'h30, 1'b0, 1'b1);
        send_beat(8'h31, 1'b0, 1'b1);
        send_beat(8'h31, 1'b0, 1'b1);
        send_beat(8'h37, 1'b1, 1'b1);
        idle(4);

        // Port 2 stalls for 5 cycles mid-packet
        fork
            send_pkt(4'd2, 6, 0, 0);
            begin
                repeat (2) @(posedge clk);
                #1 m_axis_tready = 4'b1011;
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_tready", s_axis_tready, 1'b0);
                end
                @(posedge clk);
                #1 m_axis_tready = 4'hF;
            end
        join
        idle(4);

        // Ten back-to-back single-beat packets alternating ports 0 and 3
        for (int k = 0; k < 10; k++) send_pkt((k % 2 == 0) ? 4'd0 : 4'd3, 1, 1, 0);
        idle(4);
        chk("fwd_after_singles", fwd_pkt_count, 32'd16);

        // Random packets with random egress back-pressure
        rnd_done = 0;
        fork
            begin
                for (int k = 0; k < 30; k++) send_pkt(4'($urandom_range(7, 0)), $urandom_range(4, 1), 0, 2);
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 m_axis_tready = 4'($urandom);
                end
                m_axis_tready = 4'hF;
            end
        join
        idle(6);

        // Twenty drops push the 4-bit build into saturation
        for (int k = 0; k < 20; k++) send_pkt(4'($urandom_range(15, 4)), 1, 1, 1);
        idle(4);
        chk("drop_cnt_w4_saturated", c4_drop, 4'hF);

        // Reset in the middle of a port-1 packet
        send_beat(8'h51, 1'b0, 1'b0);
        send_beat(8'h51, 1'b0, 1'b0);
        sreset = 1'b1;
        @(posedge clk);
        #1 sreset = 1'b0;
        @(negedge clk);
        chk("mid_rst_tvalid", m_axis_tvalid, 4'h0);
        chk("mid_rst_tdata", m_axis_tdata, 512'h0);
        chk("mid_rst_tkeep", m_axis_tkeep, 64'h0);
        chk("mid_rst_tlast", m_axis_tlast, 1'b0);
        chk("mid_rst_tuser", m_axis_tuser, 4'h0);
        chk("mid_rst_fwd", fwd_pkt_count, 32'd0);
        chk("mid_rst_drop", drop_pkt_count, 32'd0);
        chk("mid_rst_pulse", drop_pulse, 1'b0);
        chk("mid_rst_tready", s_axis_tready, 1'b1);
        @(posedge clk);
        #1;
        send_pkt(4'd3, 2, 1, 0);
        idle(4);
        chk("fwd_after_reset", fwd_pkt_count, 32'd1);

        for (int p = 0; p < 4; p++) chk("queue_drained", exp_q[p].size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
